disp_line_buffer: RTL
=====================

Name: disp_line_buffer

Overview:
- Parametrised successor of the single 256x7 post-processing SRAM: a ROWS-deep circular line buffer for the disparity stream.
- Accepts raster-order pixels through a valid/ready handshake and emits, per accepted pixel, a vertical window of ROWS+1 taps (current row plus ROWS previous rows, same column), with a per-tap validity mask.
- Feeds the median/consistency filters in the post-processing chain.

Parameters:
- DWIDTH, 7, disparity word width.
- COLS, 256, pixels per row. Any value >= 2.
- AWIDTH, 8, column address width, $clog2(COLS).
- ROWS, 2, stored previous rows, i.e. number of RAM banks. Window height is ROWS+1; ROWS >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_sof  in  1  qualifies the first pixel of a frame (sampled on accept).
- in_data  in  DWIDTH  disparity pixel.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream ready.
- out_data  out  (ROWS+1)*DWIDTH  taps. Slice k is row n-k; k=0 is the current pixel.
- out_mask  out  ROWS  bit k-1 set when row n-k exists in the current frame.
- out_col  out  AWIDTH  column of the window.
- out_eol  out  1  window is the last column of a row.

Behaviour:
- Reset: in_ready=1 combinationally after reset. out_valid, out_data, out_mask, out_col and out_eol are 0. col, row_ptr and rows_seen are 0. RAM contents are not reset.
- Reset mid-frame clears all counters; stale RAM rows are masked via rows_seen=0.
- Handshake: in_ready = !out_valid || out_ready.
  - A pixel is accepted (acc) when in_valid && in_ready.
  - Output registers update only on acc; out_valid takes the value of acc.
  - Stall holds all outputs and RAM read data stable.
- Latency: exactly 1 cycle from acc to out_valid.
- Counters and pointers on acc:
  - If in_sof: this pixel is treated as col=0 with rows_seen=0 and row_ptr=0, regardless of prior state, including mid-row.
  - col increments. At col==COLS-1 it wraps to 0, out_eol=1, row_ptr=(row_ptr+1) mod ROWS, and rows_seen increments, saturating at ROWS.
- Banks: ROWS simple-dual-port banks of COLS x DWIDTH.
  - On acc, all banks are read at address col.
  - Bank row_ptr is written with in_data at col in the same cycle.
  - Banks are read-first: the written bank returns its old content, which is row n-ROWS.
- Tap mapping for k=1..ROWS: slice k comes from bank (row_ptr-k) mod ROWS, so k=ROWS maps to bank row_ptr.
  - Slice 0 is in_data registered.
  - Pointer arithmetic is done modulo ROWS without a power-of-2 requirement.
- out_mask bit k-1 = (rows_seen_at_accept >= k), using the value after any sof clear. Masked taps carry don't-care data; the bench must not check them.
- Simultaneous events:
  - sof on the last column: sof wins, so col becomes 1 afterwards and out_eol=0.
  - sof while stalled is impossible, since nothing is accepted.
- No frame-height limit; row_ptr wraps indefinitely.

Decomposition:
- Package lb_pkg holds:
  - the tap slice helper, a function returning the bank index for (row_ptr, k, ROWS);
  - localparams for window width (ROWS+1)*DWIDTH.
- One sub-module: lb_bank_ram.
  - Parametrised DWIDTH/AWIDTH/WORDS, read-first, shared rd/wr enable, registered q.
  - q resets to 0 asynchronously on rst low; array not reset.
  - Instantiated ROWS times with a generate loop.

Test Plan:
- COLS=4, ROWS=2: sof then 12 pixels valued 0..11, out_ready=1.
  - Row 0 windows have mask 00; row 1 mask 01; row 2 mask 11.
  - Pixel 10 window is {10,6,2} with out_col=2. out_eol=1 on pixels 3, 7 and 11.
- Read-first check: ROWS=2, pixel 8 accepted while bank 0 (holding pixel 0, row 0, col 0) is written at col 0. Tap 2 must be 0, not 8.
- Backpressure: hold out_ready=0 for 3 cycles after the first window.
  - in_ready=0; out_data, out_col and out_valid stay stable.
  - No pixel is lost or duplicated; release resumes at the next column.
- Mid-row sof: after 6 pixels (COLS=4), assert sof on the 7th. out_col=0 and out_mask=00 for that pixel, and the following pixel has out_col=1.
- Async reset low mid-frame for 1 cycle.
  - Outputs go 0 immediately and in_ready=1.
  - The next accepted pixel has col=0 and mask=00, even without sof.
- Non-power-of-2: ROWS=3, COLS=5, 20 pixels. Tap k always equals pixel value −5k when its mask bit is set, including across row_ptr wrap 2→0.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared helpers for the disparity line buffer: window sizing and the
// tap-to-bank mapping used by the output mux.
package lb_pkg;

    localparam int unsigned LB_DEF_DWIDTH = 7;
    localparam int unsigned LB_DEF_ROWS   = 2;
    localparam int unsigned LB_DEF_WIN_W  = (LB_DEF_ROWS + 1) * LB_DEF_DWIDTH;

    function automatic int unsigned win_width(input int unsigned rows,
                                              input int unsigned dwidth);
        return (rows + 1) * dwidth;
    endfunction

    // Bank holding row n-k, given the write pointer at accept time;
    // k == rows lands on row_ptr itself (read-first old content).
    function automatic int unsigned bank_idx(input int unsigned row_ptr,
                                             input int unsigned k,
                                             input int unsigned rows);
        return (row_ptr + rows - (k % rows)) % rows;
    endfunction

endpackage

// File: rtl/lb_bank_ram.sv
// One line-buffer bank: simple dual-port, read-first, registered output.
// The output register is cleared by reset; the array is not.
module lb_bank_ram #(
    parameter int unsigned DWIDTH = 7,
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned WORDS  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] d_i,
    output logic [DWIDTH-1:0] q_o
);

    logic [DWIDTH-1:0] mem [WORDS];
    logic [DWIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem[addr_i] <= d_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= mem[addr_i];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/disp_line_buffer.sv
// ROWS-deep circular line buffer: emits a vertical window of ROWS+1 taps per
// accepted raster pixel, with a mask marking taps that exist in this frame.
module disp_line_buffer
    import lb_pkg::*;
#(
    parameter int unsigned DWIDTH = 7,
    parameter int unsigned COLS   = 256,
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned ROWS   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_sof,
    input  logic [DWIDTH-1:0]                    in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [win_width(ROWS, DWIDTH)-1:0]   out_data,
    output logic [ROWS-1:0]                      out_mask,
    output logic [AWIDTH-1:0]                    out_col,
    output logic                                 out_eol
);

    localparam int unsigned WIN_W = win_width(ROWS, DWIDTH);
    localparam int unsigned PW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned SW    = $clog2(ROWS + 1);

    logic              acc;
    logic              last;
    logic [AWIDTH-1:0] col_q, col_cur, col_d;
    logic [PW-1:0]     row_ptr_q, rp_cur, rp_d;
    logic [SW-1:0]     rows_seen_q, rs_cur, rs_d;
    logic [ROWS-1:0]   mask_d;

    logic              out_valid_q;
    logic [DWIDTH-1:0] d0_q;
    logic [ROWS-1:0]   mask_q;
    logic [AWIDTH-1:0] col_out_q;
    logic              eol_q;
    logic [PW-1:0]     rp_out_q;
    logic [PW-1:0]     sel;

    logic [DWIDTH-1:0] bank_q [ROWS];

    assign in_ready = !out_valid_q || out_ready;
    assign acc      = in_valid && in_ready;

    // sof overrides all position state for the pixel that carries it
    assign col_cur = in_sof ? '0 : col_q;
    assign rp_cur  = in_sof ? '0 : row_ptr_q;
    assign rs_cur  = in_sof ? '0 : rows_seen_q;
    assign last    = (col_cur == AWIDTH'(COLS - 1));

    always_comb begin
        col_d  = last ? '0 : col_cur + AWIDTH'(1);
        rp_d   = rp_cur;
        rs_d   = rs_cur;
        mask_d = '0;
        if (last) begin
            rp_d = (rp_cur == PW'(ROWS - 1)) ? '0 : rp_cur + PW'(1);
            if (rs_cur != SW'(ROWS)) begin
                rs_d = rs_cur + SW'(1);
            end
        end
        for (int unsigned k = 1; k <= ROWS; k++) begin
            mask_d[k-1] = (rs_cur >= SW'(k));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_ptr_q   <= '0;
            rows_seen_q <= '0;
            out_valid_q <= 1'b0;
            d0_q        <= '0;
            mask_q      <= '0;
            col_out_q   <= '0;
            eol_q       <= 1'b0;
            rp_out_q    <= '0;
        end else begin
            if (in_ready) begin
                out_valid_q <= in_valid;
            end
            if (acc) begin
                col_q       <= col_d;
                row_ptr_q   <= rp_d;
                rows_seen_q <= rs_d;
                d0_q        <= in_data;
                mask_q      <= mask_d;
                col_out_q   <= col_cur;
                eol_q       <= last;
                rp_out_q    <= rp_cur;
            end
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_bank
        lb_bank_ram #(
            .DWIDTH(DWIDTH),
            .AWIDTH(AWIDTH),
            .WORDS (COLS)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .en_i  (acc),
            .we_i  (rp_cur == PW'(g)),
            .addr_i(col_cur),
            .d_i   (in_data),
            .q_o   (bank_q[g])
        );
    end

    // Bank selection uses the pointer captured with the pixel, so the taps
    // stay aligned with the registered read data through a stall.
    always_comb begin
        out_data                = '0;
        sel                     = '0;
        out_data[DWIDTH-1:0]    = d0_q;
        for (int unsigned k = 1; k <= ROWS; k++) begin
            sel = PW'(bank_idx(32'(rp_out_q), k, ROWS));
            out_data[k*DWIDTH +: DWIDTH] = bank_q[sel];
        end
    end

    assign out_valid = out_valid_q;
    assign out_mask  = mask_q;
    assign out_col   = col_out_q;
    assign out_eol   = eol_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, WIN_W[0]};

endmodule
